// File: rtl/demux8_deserializer_pkg.sv
// Shared types and defaults for the serial-to-word deserializer.
package demux8_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;
endpackage

// File: rtl/demux8_deserializer_if.sv
// Bit-stream in / word-out bundle; master drives the serial side, slave is the deserializer.
interface demux8_deserializer_if
    import demux8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int SEL_W = $clog2(WIDTH);

    logic             clear;
    logic             din_valid;
    logic             din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [SEL_W-1:0] s;
    logic             busy;
    logic             par_err;

    modport master (
        output clear, din_valid, din,
        input  dout, dout_valid, s, busy, par_err
    );

    modport slave (
        input  clear, din_valid, din,
        output dout, dout_valid, s, busy, par_err
    );
endinterface

// File: rtl/demux8_deserializer_dec3to8.sv
// Slot-index to one-hot write-enable decoder, all-zero when en is low.
module dec3to8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] we
);
    always_comb begin
        we = '0;
        if (en) we[sel] = 1'b1;
    end
endmodule

// File: rtl/demux8_deserializer.sv
// Serial bit stream to WIDTH-bit word deserializer, LSB first, one-cycle completion strobe.
// Build option PARITY_CHECK_EN: each word is followed by an even-parity bit checked into par_err.
module demux8_deserializer
    import demux8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    demux8_deserializer_if.slave bus
);
    localparam int SEL_W = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] s_q, s_nxt;
    logic [WIDTH-1:0] shadow, we;
    logic [WIDTH-1:0] dout_q, dout_nxt;
    logic             dv_q, dv_nxt;
    logic             wr_en;

`ifdef PARITY_CHECK_EN
    logic pe_q, pe_nxt;
`else
    // Word as it stands once the current bit lands; used at the final slot.
    logic [WIDTH-1:0] merged;
    assign merged = (shadow & ~we) | ({WIDTH{bus.din}} & we);
`endif

    dec3to8 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dec (
        .sel (s_q),
        .en  (wr_en),
        .we  (we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        dout_nxt  = dout_q;
        dv_nxt    = 1'b0;
        wr_en     = 1'b0;
`ifdef PARITY_CHECK_EN
        pe_nxt    = pe_q;
`endif
        if (bus.clear) begin
            state_nxt = IDLE;
            s_nxt     = '0;
        end else if (bus.din_valid) begin
            case (state)
                IDLE, COLLECT: begin
                    wr_en = 1'b1;
                    s_nxt = s_q + 1'b1;   // wraps to 0 after the last slot
                    if (s_q == LAST) begin
`ifdef PARITY_CHECK_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
                        dout_nxt  = merged;
                        dv_nxt    = 1'b1;
`endif
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
`ifdef PARITY_CHECK_EN
                    // Incoming bit is the even-parity bit; it never enters the word.
                    dout_nxt = shadow;
                    dv_nxt   = 1'b1;
                    pe_nxt   = (^shadow) ^ bus.din;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            shadow <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            s_q    <= s_nxt;
            dout_q <= dout_nxt;
            dv_q   <= dv_nxt;
            if (bus.clear) begin
                shadow <= '0;
            end else begin
                for (int i = 0; i < WIDTH; i++)
                    if (we[i]) shadow[i] <= bus.din;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pe_q <= 1'b0;
        else     pe_q <= pe_nxt;
    end
    assign bus.par_err = pe_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.s          = s_q;
    assign bus.busy       = (state != IDLE);
endmodule
